// File: rtl/id_ex_skid_stage_pkg.sv
// Shared decode/execute boundary types: bundle layout and skid-buffer occupancy encoding.
package id_ex_skid_stage_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 16;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_val;
        logic [XLEN-1:0]      rs2_val;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rd;
        logic [CTRL_W-1:0]    ctrl;
    } bundle_t;

    // bit 0 = main entry valid, bit 1 = skid entry valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } occ_t;

endpackage

// File: rtl/id_ex_skid_stage_sat_counter.sv
// Saturating up-counter, adds 0..2 per cycle.
// Latency: count reflects an increment one cycle after it is presented.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W:0]   sum;

    assign sum   = {1'b0, count_q} + {{(W-1){1'b0}}, inc};
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc != 2'd0) begin
            count_q <= sum[W] ? {W{1'b1}} : sum[W-1:0];
        end
    end

endmodule

// File: rtl/id_ex_skid_stage.sv
// Decode-to-execute register stage with a two-entry skid buffer and flush support.
// Latency: one cycle from input fire to out_valid; one bundle per cycle sustained.
// Backpressure: in_ready is a register bit (skid empty), never combinational from out_ready.
module id_ex_skid_stage #(
    parameter int XLEN   = id_ex_skid_stage_pkg::XLEN,
    parameter int CTRL_W = id_ex_skid_stage_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  flush_count
);

    import id_ex_skid_stage_pkg::*;

    occ_t    state_q, state_d;
    bundle_t main_q, skid_q, in_bundle;
    logic    main_valid, skid_valid;
    logic    in_fire, out_fire;
    logic    load_main, load_skid, move_skid;
    logic [1:0] flush_inc;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    assign in_bundle = '{pc: in_pc, rs1_val: in_rs1_val, rs2_val: in_rs2_val,
                         imm: in_imm, rd: in_rd, ctrl: in_ctrl};

    // New data goes to main when main is free or draining this cycle, else to skid.
    assign load_main = in_fire & (~main_valid | out_fire);
    assign load_skid = in_fire & main_valid & ~out_fire;
    assign move_skid = skid_valid & out_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_d = TWO;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                TWO:     if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            if (move_skid)      main_q <= skid_q;
            else if (load_main) main_q <= in_bundle;
            if (load_skid)      skid_q <= in_bundle;
        end
    end

    assign out_pc      = main_q.pc;
    assign out_rs1_val = main_q.rs1_val;
    assign out_rs2_val = main_q.rs2_val;
    assign out_imm     = main_q.imm;
    assign out_rd      = main_q.rd;
    // Bubbles must never carry a live control word into execute.
    assign out_ctrl    = main_valid ? main_q.ctrl : '0;

    // Entries lost to a flush: main unless it leaves this cycle, plus skid.
    assign flush_inc = flush ? ({1'b0, main_valid & ~out_fire} + {1'b0, skid_valid}) : 2'd0;

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Decode-to-execute pipeline boundary for the 64-bit RISC-V core.
- Registers the decoded bundle: PC, rs1/rs2 operand values, the selected 64-bit immediate from the decode immediate mux, rd index and control word.
- Hands the bundle to execute over a valid/ready handshake, with a two-entry skid buffer so in_ready is a registered signal.
- Supports pipeline flush on branch redirect and counts flushed (discarded) instructions.

Parameters:
- XLEN, 64, data width of PC, operands and immediate.
- CTRL_W, 16, width of the opaque execute control word.
- CNT_W, 32, width of the flushed-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered instructions (branch redirect / trap).
- in_valid  input  1  decode presents a bundle.
- in_ready  output  1  stage can accept a bundle; registered.
- in_pc  input  XLEN  instruction PC.
- in_rs1_val  input  XLEN  rs1 operand.
- in_rs2_val  input  XLEN  rs2 operand.
- in_imm  input  XLEN  selected immediate.
- in_rd  input  5  destination register index.
- in_ctrl  input  CTRL_W  execute control word.
- out_valid  output  1  bundle available to execute.
- out_ready  input  1  execute accepts the bundle.
- out_pc, out_rs1_val, out_rs2_val, out_imm  output  XLEN each  registered bundle fields.
- out_rd  output  5  registered rd.
- out_ctrl  output  CTRL_W  registered control word; forced to 0 when out_valid=0.
- flush_count  output  CNT_W  saturating count of instructions discarded by flush.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with its own valid bit.
- Occupancy states:
  - EMPTY: no entries valid.
  - ONE: main valid, skid empty.
  - TWO: both valid.
- in_ready = NOT skid_valid, registered. Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- Transitions, evaluated only when flush=0:
  - EMPTY, in fire → ONE; data loads into main.
  - ONE, in fire with no out fire → TWO; data loads into skid.
  - ONE, in fire with out fire → ONE; main reloads with new data.
  - ONE, out fire with no in fire → EMPTY.
  - TWO, out fire → ONE; skid moves to main, skid_valid clears. Input cannot fire in TWO because in_ready=0.
  - No event → hold state and data.
- Ordering: strict FIFO; bundles leave in arrival order. The output bundle holds stable while out_valid=1 and out_ready=0.
- Latency: a bundle accepted in cycle N is visible on the outputs in cycle N+1 at the earliest. Throughput is one bundle per cycle when out_ready is held high.
- Flush, effective next edge:
  - Both valid bits clear; the state becomes EMPTY.
  - The input presented in the flush cycle is dropped, even if in_valid&in_ready.
  - An out fire in the flush cycle still counts as delivered and is not counted as flushed.
  - in_ready is 1 in the next cycle.
- flush_count: on flush, adds the number of entries discarded (0, 1 or 2). An entry is discarded if it is valid and not consumed by an out fire in that cycle; the flush-cycle input is not counted. Saturates at all-ones and does not wrap.
- Reset, dominates flush:
  - All valid bits clear, so out_valid=0 and in_ready=1 from the cycle after reset.
  - Data registers clear to 0; flush_count clears to 0.
  - Reset mid-operation discards everything without incrementing flush_count.
- out_ctrl gating: 0 whenever out_valid=0, so no execute write-enable is asserted on a bubble.
- No combinational path from out_ready to in_ready.

Decomposition:
- Shared core package holds:
  - XLEN.
  - REG_IDX_W = 5.
  - The bundle typedef (pc, rs1_val, rs2_val, imm, rd, ctrl).
  - The occupancy state encoding: EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11.
- One natural sub-module: sat_counter (parameterised width, increment by 0–2, saturating, synchronous reset), used for flush_count.

Test Plan:
- Reset, then idle → out_valid=0, in_ready=1, out_ctrl=0, flush_count=0.
- Streaming: out_ready=1, three bundles with pc=0x1000/0x1004/0x1008 on consecutive cycles → each appears one cycle later; in_ready stays 1.
- Backpressure: out_ready=0, send pc=0x2000 then 0x2004 → in_ready=0 after the second; out_pc holds 0x2000. Raise out_ready → 0x2000, then 0x2004 delivered in order; in_ready returns to 1.
- Flush in TWO with out_ready=0, while in_valid=1 carrying pc=0x3000 → next cycle out_valid=0, in_ready=1, flush_count=2; 0x3000 is never output.
- Flush in ONE with out_ready=1 → the delivered bundle is not counted, so flush_count is unchanged. Then preload flush_count near max (force) and flush in TWO → flush_count saturates at 0xFFFFFFFF.
- Reset asserted in TWO with flush=1 → next cycle EMPTY, in_ready=1, flush_count=0, all out fields 0.
